// File: rtl/ft245_fifo_responder.sv
// ft245_fifo_responder: FT245-style FIFO responder with host-side push/pop queues.
// Optional FT245_RESPONDER_LOOPBACK_EN adds loopback_i to steer FPGA writes into RXQ.
module ft245_fifo_responder #(
  parameter int DEPTH           = 16,
  parameter int INACTIVE_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  inout  wire  [7:0]               data_io,
  output logic                     nRXF_o,
  output logic                     nTXE_o,
  input  logic                     nRD_i,
  input  logic                     nWR_i,
  input  logic                     host_tx_valid_i,
  input  logic [7:0]               host_tx_data_i,
  output logic                     host_tx_ready_o,
  output logic                     host_rx_valid_o,
  output logic [7:0]               host_rx_data_o,
  input  logic                     host_rx_ready_i,
  output logic [$clog2(DEPTH):0]   rxq_count_o,
  output logic [$clog2(DEPTH):0]   txq_count_o,
  output logic                     overflow_err_o,
  output logic                     underrun_err_o,
  output logic                     proto_err_o
`ifdef FT245_RESPONDER_LOOPBACK_EN
  ,input logic                     loopback_i
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, INACT} st_t;
  st_t st [2];
  st_t st_n [2];
  logic [3:0] ic [2];
  logic [3:0] ic_n [2];
  logic nrd_q, nwr_q, rd_ok, both, lb;
  logic [1:0] strb, arm, fall, rise;
  logic [7:0] rx_mem [DEPTH];
  logic [7:0] tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0] rx_cnt, tx_cnt, rx_cnt_n, tx_cnt_n;
  logic rx_empty, rx_full, tx_full, wr_go, wr_to_rx, wr_to_tx;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0] rx_din;
`ifdef FT245_RESPONDER_LOOPBACK_EN
  assign lb = loopback_i;
`else
  assign lb = 1'b0;
`endif
  assign strb = {nWR_i, nRD_i};
  // arm blocks a strobe held low across reset release from looking like a new edge
  assign fall = arm & {nwr_q, nrd_q} & ~strb;
  assign rise = ~{nwr_q, nrd_q} & strb;
  assign both = ~nRD_i & ~nWR_i;
  assign rx_empty = rx_cnt == '0;
  assign rx_full = rx_cnt == CW'(DEPTH);
  assign tx_full = tx_cnt == CW'(DEPTH);
  assign wr_go = fall[1] & nRD_i;
  assign wr_to_rx = wr_go & lb;
  assign wr_to_tx = wr_go & ~lb;
  assign host_tx_ready_o = ~reset_i & ~rx_full & ~wr_to_rx;
  assign host_rx_valid_o = ~reset_i & (tx_cnt != '0);
  assign host_rx_data_o = tx_mem[tx_rp];
  assign rx_push = (wr_to_rx & ~rx_full) | (host_tx_valid_i & host_tx_ready_o);
  assign rx_din = wr_to_rx ? data_io : host_tx_data_i;
  assign rx_pop = rise[0] & rd_ok;
  assign tx_push = wr_to_tx & ~tx_full;
  assign tx_pop = host_rx_valid_o & host_rx_ready_i;
  assign rx_cnt_n = rx_cnt + CW'(rx_push) - CW'(rx_pop);
  assign tx_cnt_n = tx_cnt + CW'(tx_push) - CW'(tx_pop);
  assign rxq_count_o = rx_cnt;
  assign txq_count_o = tx_cnt;
  assign data_io = (~reset_i & ~nRD_i & nWR_i & ~rx_empty) ? rx_mem[rx_rp] : 8'bz;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_n[i] = st[i];
      ic_n[i] = ic[i];
      if (fall[i]) st_n[i] = ACTIVE;
      else if (st[i] == ACTIVE && rise[i]) begin
        st_n[i] = INACT;
        ic_n[i] = '0;
      end else if (st[i] == INACT) begin
        st_n[i] = (ic[i] == 4'(INACTIVE_CYCLES - 1)) ? IDLE : INACT;
        ic_n[i] = ic[i] + 4'd1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      {nwr_q, nrd_q} <= 2'b11;
      arm <= strb;
      rd_ok <= 1'b0;
      st <= '{IDLE, IDLE};
      ic <= '{default: '0};
      rx_wp <= '0;
      rx_rp <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
      rx_cnt <= '0;
      tx_cnt <= '0;
      nRXF_o <= 1'b1;
      nTXE_o <= 1'b1;
      overflow_err_o <= 1'b0;
      underrun_err_o <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      {nwr_q, nrd_q} <= strb;
      arm <= arm | strb;
      rd_ok <= fall[0] ? (~rx_empty & nWR_i) : (rd_ok & ~both & ~rise[0]);
      st <= st_n;
      ic <= ic_n;
      rx_wp <= rx_wp + AW'(rx_push);
      rx_rp <= rx_rp + AW'(rx_pop);
      tx_wp <= tx_wp + AW'(tx_push);
      tx_rp <= tx_rp + AW'(tx_pop);
      rx_cnt <= rx_cnt_n;
      tx_cnt <= tx_cnt_n;
      nRXF_o <= (rx_cnt_n == '0) || (st_n[0] != IDLE);
      nTXE_o <= (tx_cnt_n == CW'(DEPTH)) || (st_n[1] != IDLE);
      overflow_err_o <= (wr_to_tx & tx_full) | (wr_to_rx & rx_full);
      underrun_err_o <= fall[0] & rx_empty & nWR_i;
      proto_err_o <= both & ~(~nrd_q & ~nwr_q);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wp] <= rx_din;
    if (tx_push) tx_mem[tx_wp] <= data_io;
  end
endmodule

// File: tb/tb_ft245_fifo_responder.sv
// tb_ft245_fifo_responder: directed vector table plus hand sequences for ft245_fifo_responder.
module tb_ft245_fifo_responder;
  logic clk = 0, reset = 1, nrd = 1, nwr = 1, hv = 0, hr = 0, tb_oe = 0, lb = 0;
  logic [7:0] hd = 0, wd = 0;
  tri1 [7:0] data_io;
  wire nrxf, ntxe, htr, hrv, oerr, uerr, perr;
  wire [7:0] hrd;
  wire [4:0] rc, tc;
  int tests = 0, fails = 0, nerr, tot;
  assign data_io = tb_oe ? wd : 8'bz;
  always #5 clk = ~clk;
  ft245_fifo_responder dut (
    .clk_i(clk), .reset_i(reset), .data_io(data_io), .nRXF_o(nrxf), .nTXE_o(ntxe),
    .nRD_i(nrd), .nWR_i(nwr), .host_tx_valid_i(hv), .host_tx_data_i(hd),
    .host_tx_ready_o(htr), .host_rx_valid_o(hrv), .host_rx_data_o(hrd),
    .host_rx_ready_i(hr), .rxq_count_o(rc), .txq_count_o(tc),
    .overflow_err_o(oerr), .underrun_err_o(uerr), .proto_err_o(perr)
`ifdef FT245_RESPONDER_LOOPBACK_EN
    , .loopback_i(lb)
`endif
  );
  typedef struct {
    logic rd, wr, hv, hr;
    logic [7:0] wd, hd;
    logic xrxf, xtxe;
    int xrc, xtc, xbus;
    logic xue, xpe, xhv;
    int xhd;
  } vec_t;
  vec_t t [29];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr_byte(input logic [7:0] b, output int n);
    n = 0;
    nwr = 0; wd = b; tb_oe = 1;
    repeat (2) begin step(); n += int'(oerr); end
    nwr = 1; tb_oe = 0;
    repeat (3) begin step(); n += int'(oerr); end
  endtask
  initial begin
    // rd wr hv hr wd hd | nRXF nTXE rxc txc bus(FF=z,-1 skip) ue pe hv hd(-1 skip)
    t[0]  = '{1,1,0,0,8'h00,8'h00, 1,0,0,0,'hFF, 0,0,0,-1};
    t[1]  = '{1,1,1,0,8'h00,8'hA5, 0,0,1,0,'hFF, 0,0,0,-1};
    t[2]  = '{1,1,1,0,8'h00,8'h3C, 0,0,2,0,'hFF, 0,0,0,-1};
    t[3]  = '{0,1,0,0,8'h00,8'h00, 1,0,2,0,'hA5, 0,0,0,-1};
    t[4]  = '{0,1,0,0,8'h00,8'h00, 1,0,2,0,'hA5, 0,0,0,-1};
    t[5]  = '{1,1,0,0,8'h00,8'h00, 1,0,1,0,'hFF, 0,0,0,-1};
    t[6]  = '{1,1,0,0,8'h00,8'h00, 1,0,1,0,'hFF, 0,0,0,-1};
    t[7]  = '{1,1,0,0,8'h00,8'h00, 0,0,1,0,'hFF, 0,0,0,-1};
    t[8]  = '{0,1,0,0,8'h00,8'h00, 1,0,1,0,'h3C, 0,0,0,-1};
    t[9]  = '{0,1,0,0,8'h00,8'h00, 1,0,1,0,'h3C, 0,0,0,-1};
    t[10] = '{1,1,0,0,8'h00,8'h00, 1,0,0,0,'hFF, 0,0,0,-1};
    t[11] = '{1,1,0,0,8'h00,8'h00, 1,0,0,0,'hFF, 0,0,0,-1};
    t[12] = '{1,1,0,0,8'h00,8'h00, 1,0,0,0,'hFF, 0,0,0,-1};
    t[13] = '{0,1,0,0,8'h00,8'h00, 1,0,0,0,'hFF, 1,0,0,-1};
    t[14] = '{0,1,0,0,8'h00,8'h00, 1,0,0,0,'hFF, 0,0,0,-1};
    t[15] = '{1,1,0,0,8'h00,8'h00, 1,0,0,0,'hFF, 0,0,0,-1};
    t[16] = '{1,1,0,0,8'h00,8'h00, 1,0,0,0,'hFF, 0,0,0,-1};
    t[17] = '{1,1,0,0,8'h00,8'h00, 1,0,0,0,'hFF, 0,0,0,-1};
    t[18] = '{1,0,0,0,8'h11,8'h00, 1,1,0,1,-1,    0,0,1,'h11};
    t[19] = '{1,0,0,0,8'h11,8'h00, 1,1,0,1,-1,    0,0,1,'h11};
    t[20] = '{1,1,0,0,8'h00,8'h00, 1,1,0,1,'hFF, 0,0,1,'h11};
    t[21] = '{1,1,0,0,8'h00,8'h00, 1,1,0,1,'hFF, 0,0,1,'h11};
    t[22] = '{1,1,0,0,8'h00,8'h00, 1,0,0,1,'hFF, 0,0,1,'h11};
    t[23] = '{1,1,0,1,8'h00,8'h00, 1,0,0,0,'hFF, 0,0,0,-1};
    t[24] = '{1,1,1,0,8'h00,8'h77, 0,0,1,0,'hFF, 0,0,0,-1};
    t[25] = '{0,0,0,0,8'h99,8'h00, 1,1,1,0,-1,    0,1,0,-1};
    t[26] = '{1,1,0,0,8'h00,8'h00, 1,1,1,0,'hFF, 0,0,0,-1};
    t[27] = '{1,1,0,0,8'h00,8'h00, 1,1,1,0,'hFF, 0,0,0,-1};
    t[28] = '{1,1,0,0,8'h00,8'h00, 0,0,1,0,'hFF, 0,0,0,-1};
    step(); step();
    chk("reset nRXF", nrxf, 1); chk("reset nTXE", ntxe, 1);
    chk("reset counts", {rc, tc}, 0); chk("reset host_tx_ready", htr, 0);
    chk("reset host_rx_valid", hrv, 0); chk("reset bus", data_io, 8'hFF);
    chk("reset errs", {oerr, uerr, perr}, 0);
    reset = 0;
    for (int k = 0; k < 29; k++) begin
      nrd = t[k].rd; nwr = t[k].wr; tb_oe = ~t[k].wr; wd = t[k].wd;
      hv = t[k].hv; hd = t[k].hd; hr = t[k].hr;
      step();
      chk($sformatf("v%0d nRXF", k), nrxf, t[k].xrxf);
      chk($sformatf("v%0d nTXE", k), ntxe, t[k].xtxe);
      chk($sformatf("v%0d rxq_count", k), rc, t[k].xrc);
      chk($sformatf("v%0d txq_count", k), tc, t[k].xtc);
      if (t[k].xbus >= 0) chk($sformatf("v%0d data_io", k), data_io, t[k].xbus);
      chk($sformatf("v%0d underrun", k), uerr, t[k].xue);
      chk($sformatf("v%0d proto", k), perr, t[k].xpe);
      chk($sformatf("v%0d overflow", k), oerr, 0);
      chk($sformatf("v%0d host_rx_valid", k), hrv, t[k].xhv);
      if (t[k].xhd >= 0) chk($sformatf("v%0d host_rx_data", k), hrd, t[k].xhd);
    end
    hr = 0; tb_oe = 0; nrd = 1; nwr = 1;
    // strobe re-asserted during INACTIVE is honoured
    hv = 1; hd = 8'h88; step(); hv = 0;
    chk("abort rxq_count", rc, 2);
    nrd = 0; step(); chk("abort first byte", data_io, 8'h77);
    nrd = 1; step(); chk("abort pop", rc, 1);
    nrd = 0; step(); chk("abort second byte", data_io, 8'h88); chk("abort no underrun", uerr, 0);
    nrd = 1; step(); chk("abort drain", rc, 0);
    repeat (3) step();
    // fill TXQ then overflow
    tot = 0;
    for (int i = 0; i < 16; i++) begin wr_byte(8'h20 + 8'(i), nerr); tot += nerr; end
    chk("fill no overflow", tot, 0); chk("fill txq_count", tc, 16); chk("full nTXE", ntxe, 1);
    wr_byte(8'hFF, nerr);
    chk("overflow pulses", nerr, 1); chk("overflow txq_count", tc, 16); chk("overflow nTXE", ntxe, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain %0d", i), {hrv, hrd}, 9'h120 + 9'(i));
      hr = 1; step(); hr = 0;
    end
    chk("drained valid", hrv, 0); chk("drained count", tc, 0);
    // reset in the middle of a read, strobe held low past release
    hv = 1; hd = 8'h44; step(); hv = 0;
    nrd = 0; step(); chk("midread bus", data_io, 8'h44);
    reset = 1; step();
    chk("midread reset nRXF", nrxf, 1); chk("midread reset count", rc, 0);
    chk("midread reset bus", data_io, 8'hFF);
    reset = 0;
    step(); chk("release no underrun a", uerr, 0);
    step(); chk("release no underrun b", uerr, 0); chk("release nTXE", ntxe, 0);
    nrd = 1; step();
    hv = 1; hd = 8'h55; step(); hv = 0;
    chk("release no spurious inactive", nrxf, 0); chk("release count", rc, 1);
`ifdef FT245_RESPONDER_LOOPBACK_EN
    reset = 1; step(); reset = 0; step();
    lb = 1; wr_byte(8'h5A, nerr);
    chk("loopback rxq", rc, 1); chk("loopback txq", tc, 0);
    nrd = 0; step(); chk("loopback bus", data_io, 8'h5A);
    nrd = 1; step(); chk("loopback drain", rc, 0);
    lb = 0;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
